// File: rtl/cgra_pkg.sv
// cgra_pkg: shared CGRA array dimensions and the conf loader state encoding.
package cgra_pkg;

  localparam int N_COL             = 4;
  localparam int INSTR_WIDTH       = 32;
  localparam int RCS_NUM_CREG      = 32;
  localparam int RCS_NUM_CREG_LOG2 = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } conf_loader_state_t;

endpackage

// File: rtl/conf_loader_walker.sv
// conf_loader_walker: (col, pc) iterator over the enabled columns of a load.
// Column-major, ascending column, pc 0..count-1, disabled columns skipped.
// idx_o is the running word index; last_o flags the final word of the load.
module conf_loader_walker #(
  parameter int N_COL = cgra_pkg::N_COL,
  parameter int PC_W  = cgra_pkg::RCS_NUM_CREG_LOG2,
  parameter int COL_W = (N_COL > 1) ? $clog2(N_COL) : 1,
  parameter int IDX_W = COL_W + PC_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [N_COL-1:0] mask_i,
  input  logic [PC_W:0]    count_i,
  input  logic             adv_i,
  output logic [COL_W-1:0] col_o,
  output logic [PC_W-1:0]  pc_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  logic [N_COL-1:0] mask_q;
  logic [PC_W:0]    cnt_q;
  logic [COL_W-1:0] first_col;
  logic [COL_W-1:0] next_col;
  logic             has_next;
  logic             pc_end;

  // Lowest enabled column of the incoming mask (starting point of a load).
  always_comb begin
    first_col = '0;
    for (int i = N_COL - 1; i >= 0; i--) begin
      if (mask_i[i]) first_col = COL_W'(i);
    end
  end

  // Next enabled column above the current one, if any.
  always_comb begin
    next_col = col_o;
    has_next = 1'b0;
    for (int i = N_COL - 1; i >= 0; i--) begin
      if (mask_q[i] && (COL_W'(i) > col_o)) begin
        next_col = COL_W'(i);
        has_next = 1'b1;
      end
    end
  end

  assign pc_end = ({1'b0, pc_o} == (cnt_q - {{PC_W{1'b0}}, 1'b1}));
  assign last_o = pc_end && !has_next;

  // Iterator state: reload on a new load, step on each advance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q <= '0;
      cnt_q  <= '0;
      col_o  <= '0;
      pc_o   <= '0;
      idx_o  <= '0;
    end else if (load_i) begin
      mask_q <= mask_i;
      cnt_q  <= count_i;
      col_o  <= first_col;
      pc_o   <= '0;
      idx_o  <= '0;
    end else if (adv_i) begin
      idx_o <= idx_o + {{(IDX_W-1){1'b0}}, 1'b1};
      if (pc_end) begin
        pc_o  <= '0;
        col_o <= next_col;
      end else begin
        pc_o <= pc_o + {{(PC_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/conf_loader.sv
// conf_loader: fetches kernel instruction words over an OBI-style read port
// and writes them into the per-column RC configuration register files.
// Optional feature macro: CONF_LOADER_CHECKSUM_EN adds checksum_o, the XOR
// of every instruction written during the last load.
//
// state | meaning
// IDLE  | waiting for start_i; rvalid ignored
// FETCH | issuing read requests, responses may already be returning
// DRAIN | all requests granted, waiting for the remaining responses
// DONE  | single cycle, load complete; done_o follows one cycle later
module conf_loader
  import cgra_pkg::*;
#(
  parameter int N_COL             = cgra_pkg::N_COL,
  parameter int INSTR_WIDTH       = cgra_pkg::INSTR_WIDTH,
  parameter int RCS_NUM_CREG      = cgra_pkg::RCS_NUM_CREG,
  parameter int RCS_NUM_CREG_LOG2 = cgra_pkg::RCS_NUM_CREG_LOG2,
  parameter int ADDR_WIDTH        = 32,
  parameter int MAX_OUTST         = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [ADDR_WIDTH-1:0]        base_addr_i,
  input  logic [RCS_NUM_CREG_LOG2:0]   n_instr_i,
  input  logic [N_COL-1:0]             col_mask_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         mem_req_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0]       mem_rdata_i,
  output logic [N_COL-1:0]             conf_we_o,
  output logic                         conf_ce_o,
  output logic [RCS_NUM_CREG_LOG2-1:0] conf_pc_o,
  output logic [INSTR_WIDTH-1:0]       conf_instr_o
`ifdef CONF_LOADER_CHECKSUM_EN
  ,
  output logic [INSTR_WIDTH-1:0]       checksum_o
`endif
);

  localparam int COL_W = (N_COL > 1) ? $clog2(N_COL) : 1;
  localparam int PC_W  = RCS_NUM_CREG_LOG2;
  localparam int IDX_W = COL_W + PC_W + 1;
  localparam logic [PC_W:0] CREG_MAX = (PC_W+1)'(RCS_NUM_CREG);
  localparam logic [1:0]    OUT_MAX  = 2'(MAX_OUTST);

  conf_loader_state_t    state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [1:0]            outst_q;
  logic [PC_W:0]         n_sat;
  logic                  accept;
  logic                  active;
  logic                  gnt_eff;
  logic                  rv_eff;

  logic [COL_W-1:0] req_col, rsp_col;
  logic [PC_W-1:0]  req_pc, rsp_pc;
  logic [IDX_W-1:0] req_idx, rsp_idx;
  logic             req_last, rsp_last;
  logic             unused_walk;

  assign n_sat   = (n_instr_i > CREG_MAX) ? CREG_MAX : n_instr_i;
  assign accept  = (state == IDLE) && start_i;
  assign active  = (state == FETCH) || (state == DRAIN);
  assign rv_eff  = mem_rvalid_i && active;
  // A response in the same cycle frees a slot, so the request may go out.
  assign mem_req_o  = (state == FETCH) && ((outst_q < OUT_MAX) || rv_eff);
  assign gnt_eff    = mem_req_o && mem_gnt_i;
  assign mem_addr_o = base_q + ADDR_WIDTH'({req_idx, 2'b00});

  // Request-side position only needs the word index; response side only
  // needs (col, pc).
  assign unused_walk = ^{req_col, req_pc, rsp_idx};

  conf_loader_walker #(
    .N_COL(N_COL), .PC_W(PC_W), .COL_W(COL_W), .IDX_W(IDX_W)
  ) u_req_walk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (accept),
    .mask_i (col_mask_i),
    .count_i(n_sat),
    .adv_i  (gnt_eff),
    .col_o  (req_col),
    .pc_o   (req_pc),
    .idx_o  (req_idx),
    .last_o (req_last)
  );

  conf_loader_walker #(
    .N_COL(N_COL), .PC_W(PC_W), .COL_W(COL_W), .IDX_W(IDX_W)
  ) u_rsp_walk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (accept),
    .mask_i (col_mask_i),
    .count_i(n_sat),
    .adv_i  (rv_eff),
    .col_o  (rsp_col),
    .pc_o   (rsp_pc),
    .idx_o  (rsp_idx),
    .last_o (rsp_last)
  );

  // Main sequencer with registered busy/done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      base_q <= '0;
    end else begin
      done_o <= (state == DONE);
      case (state)
        IDLE: begin
          if (start_i) begin
            base_q <= base_addr_i;
            if ((col_mask_i == '0) || (n_sat == '0)) begin
              state  <= DONE;
              busy_o <= 1'b0;
            end else begin
              state  <= FETCH;
              busy_o <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (gnt_eff && req_last) state <= DRAIN;
        end
        DRAIN: begin
          if (rv_eff && rsp_last) begin
            state  <= DONE;
            busy_o <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Granted-but-unanswered read counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outst_q <= '0;
    end else begin
      case ({gnt_eff, rv_eff})
        2'b10:   outst_q <= outst_q + 2'd1;
        2'b01:   outst_q <= outst_q - 2'd1;
        default: outst_q <= outst_q;
      endcase
    end
  end

  // Register-file write port, one cycle after each accepted response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conf_we_o    <= '0;
      conf_ce_o    <= 1'b0;
      conf_pc_o    <= '0;
      conf_instr_o <= '0;
    end else begin
      conf_we_o <= '0;
      conf_ce_o <= rv_eff;
      if (rv_eff) begin
        conf_we_o[rsp_col] <= 1'b1;
        conf_pc_o          <= rsp_pc;
        conf_instr_o       <= mem_rdata_i;
      end
    end
  end

`ifdef CONF_LOADER_CHECKSUM_EN
  // Running XOR of written instructions, restarted on each accepted load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      checksum_o <= '0;
    end else if (accept) begin
      checksum_o <= '0;
    end else if (conf_ce_o) begin
      checksum_o <= checksum_o ^ conf_instr_o;
    end
  end
`endif

endmodule
